// File: rtl/fmap_seq_counter.sv
// Per-layer pixel / feature-map sequencer with a valid/index pipeline that
// tracks the MAC datapath latency and drains before reporting layer completion.
//
// state | meaning
// IDLE  | waiting for start; latches geometry on a valid request
// RUN   | issuing pixels, stepping count and fmap_idx
// DRAIN | no new issue; pipeline flushes until empty
// DONE  | one-cycle layer_done, then back to IDLE
module fmap_seq_counter #(
  parameter int CNT_W      = 18,
  parameter int IDX_W      = 7,
  parameter int PIPE_DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] pix_per_fmap,
  input  logic [IDX_W-1:0] num_fmap,
  input  logic             stall,
  output logic [CNT_W-1:0] count,
  output logic [IDX_W-1:0] fmap_idx,
  output logic             fmap_end,
  output logic             issue,
  output logic             output_en,
  output logic [IDX_W-1:0] fmap_idx_dly,
  output logic             fmap_end_dly,
  output logic             busy,
  output logic             layer_done,
  output logic             cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   pix_lat;
  logic [IDX_W-1:0]   num_lat;
  logic [PIPE_DEPTH-1:0] pipe_vld;
  logic [PIPE_DEPTH-1:0] pipe_end;
  logic [IDX_W-1:0]   pipe_idx [PIPE_DEPTH];
  logic               last_pix;
  logic               last_fmap;
  logic               head_vld;
  logic               drained;

  assign issue        = (state == RUN) && !stall;
  assign last_pix     = (count == pix_lat - CNT_W'(1));
  assign last_fmap    = (fmap_idx == num_lat - IDX_W'(1));
  assign fmap_end     = issue && last_pix;
  assign output_en    = pipe_vld[PIPE_DEPTH-1] && !stall;
  assign fmap_idx_dly = pipe_idx[PIPE_DEPTH-1];
  assign fmap_end_dly = pipe_end[PIPE_DEPTH-1];
  assign busy         = (state != IDLE);
  assign layer_done   = (state == DONE);

  // The pipeline is empty after this edge when no stage but the last holds a
  // pixel and the last one is either empty or leaving this cycle.
  always_comb begin
    head_vld = 1'b0;
    for (int i = 0; i < PIPE_DEPTH - 1; i++) begin
      head_vld = head_vld | pipe_vld[i];
    end
  end
  assign drained = !head_vld && (!pipe_vld[PIPE_DEPTH-1] || !stall);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      fmap_idx <= '0;
      pix_lat  <= '0;
      num_lat  <= '0;
      cfg_err  <= 1'b0;
      pipe_vld <= '0;
      pipe_end <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        pipe_idx[i] <= '0;
      end
    end else begin
      cfg_err <= 1'b0;

      if (!stall) begin
        for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
          pipe_vld[i] <= pipe_vld[i-1];
          pipe_end[i] <= pipe_end[i-1];
          pipe_idx[i] <= pipe_idx[i-1];
        end
        pipe_vld[0] <= issue;
        pipe_end[0] <= fmap_end;
        pipe_idx[0] <= fmap_idx;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if ((pix_per_fmap != '0) && (num_fmap != '0)) begin
              pix_lat  <= pix_per_fmap;
              num_lat  <= num_fmap;
              count    <= '0;
              fmap_idx <= '0;
              state    <= RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            if (last_pix) begin
              count <= '0;
              if (last_fmap) begin
                fmap_idx <= '0;
                state    <= DRAIN;
              end else begin
                fmap_idx <= fmap_idx + IDX_W'(1);
              end
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (drained) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmap_seq_counter.sv
// Scoreboard bench for fmap_seq_counter: a depth-5 instance for the main
// scenarios and a depth-1 instance for the held-start case.
module tb_fmap_seq_counter;
  localparam int CW = 18;
  localparam int IW = 7;
  localparam int D  = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start, stall;
  logic [CW-1:0] pix;
  logic [IW-1:0] num;
  logic [CW-1:0] count;
  logic [IW-1:0] fmap_idx, fmap_idx_dly;
  logic          fmap_end, issue, output_en, fmap_end_dly, busy, layer_done, cfg_err;

  logic          start_b, stall_b;
  logic [CW-1:0] pix_b;
  logic [IW-1:0] num_b;
  logic [CW-1:0] count_b;
  logic [IW-1:0] fmap_idx_b, fmap_idx_dly_b;
  logic          fmap_end_b, issue_b, output_en_b, fmap_end_dly_b, busy_b, layer_done_b, cfg_err_b;

  fmap_seq_counter #(.CNT_W(CW), .IDX_W(IW), .PIPE_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_per_fmap(pix), .num_fmap(num),
    .stall(stall), .count(count), .fmap_idx(fmap_idx), .fmap_end(fmap_end),
    .issue(issue), .output_en(output_en), .fmap_idx_dly(fmap_idx_dly),
    .fmap_end_dly(fmap_end_dly), .busy(busy), .layer_done(layer_done),
    .cfg_err(cfg_err));

  fmap_seq_counter #(.CNT_W(CW), .IDX_W(IW), .PIPE_DEPTH(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pix_per_fmap(pix_b), .num_fmap(num_b),
    .stall(stall_b), .count(count_b), .fmap_idx(fmap_idx_b), .fmap_end(fmap_end_b),
    .issue(issue_b), .output_en(output_en_b), .fmap_idx_dly(fmap_idx_dly_b),
    .fmap_end_dly(fmap_end_dly_b), .busy(busy_b), .layer_done(layer_done_b),
    .cfg_err(cfg_err_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  typedef struct {int cnt; int idx; bit fend;} iss_t;
  typedef struct {int idx; bit fend;} out_t;
  iss_t iss_q[$];
  out_t out_q[$];
  int   lat_q[$];
  int   adv = 0;
  bit   done_due = 0;

  int   out_b_q[$];
  bit   prev_issue_b = 0;
  int   nout_b = 0, nissue_b = 0, ndone_b = 0;

  // Monitor for the depth-5 instance
  always @(negedge clk) begin
    if (rst) begin
      done_due = 0;
    end else begin
      if (layer_done || done_due) chk("layer_done_timing", layer_done, done_due);
      done_due = 0;
      if (issue) begin
        if (iss_q.size() == 0) begin
          fail_now("unexpected_issue", "issue=1, expected no issue");
        end else begin
          iss_t e;
          e = iss_q.pop_front();
          chk("count", count, e.cnt);
          chk("fmap_idx", fmap_idx, e.idx);
          chk("fmap_end", fmap_end, e.fend);
        end
        lat_q.push_back(adv);
      end
      if (output_en) begin
        if (out_q.size() == 0) begin
          fail_now("unexpected_output", "output_en=1, expected no output");
        end else begin
          out_t o;
          o = out_q.pop_front();
          chk("fmap_idx_dly", fmap_idx_dly, o.idx);
          chk("fmap_end_dly", fmap_end_dly, o.fend);
          if (out_q.size() == 0) done_due = 1;
        end
        if (lat_q.size() != 0) chk("latency", adv - lat_q.pop_front(), D);
      end
      if (!stall) adv++;
    end
  end

  // Monitor for the depth-1 instance
  always @(negedge clk) begin
    if (rst) begin
      prev_issue_b = 0;
    end else begin
      if (busy_b || output_en_b) chk("lag_b", output_en_b, prev_issue_b);
      prev_issue_b = issue_b;
      if (issue_b) nissue_b++;
      if (layer_done_b) ndone_b++;
      if (output_en_b) begin
        nout_b++;
        if (out_b_q.size() == 0) fail_now("unexpected_output_b", "output_en=1, expected no output");
        else chk("fmap_idx_dly_b", fmap_idx_dly_b, out_b_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_layer(input int p, input int n);
    for (int f = 0; f < n; f++)
      for (int c = 0; c < p; c++) begin
        iss_q.push_back('{cnt: c, idx: f, fend: (c == p - 1)});
        out_q.push_back('{idx: f, fend: (c == p - 1)});
      end
    start = 1'b1;
    pix   = CW'(p);
    num   = IW'(n);
    tick();
    start = 1'b0;
    pix   = CW'(7);
    num   = IW'(1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (!layer_done && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) fail_now(name, "timeout waiting for layer_done");
    tick();
    chk({name, "_busy_after"}, busy, 0);
    chk({name, "_out_left"}, out_q.size(), 0);
    chk({name, "_iss_left"}, iss_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; stall = 1'b0; pix = '0; num = '0;
    start_b = 1'b0; stall_b = 1'b0; pix_b = '0; num_b = '0;
    tick(); tick();
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_issue", issue, 0);
    chk("rst_output_en", output_en, 0);
    chk("rst_layer_done", layer_done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst = 1'b0;
    tick();

    // 1: P=4, N=3
    load_layer(4, 3);
    wait_done("t1", 60);

    // 2: P=4, N=2 with a 3-cycle stall at count=2, fmap_idx=1
    load_layer(4, 2);
    k = 0;
    while (!(count == 2 && fmap_idx == 1) && k < 30) begin tick(); k++; end
    if (k >= 30) fail_now("t2_reach", "never reached count=2 fmap_idx=1");
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("t2_stall_issue", issue, 0);
      chk("t2_stall_output_en", output_en, 0);
      chk("t2_stall_count", count, 2);
      chk("t2_stall_fmap_idx", fmap_idx, 1);
      tick();
    end
    stall = 1'b0;
    wait_done("t2", 60);

    // 3: rejected configurations
    start = 1'b1; pix = CW'(4); num = IW'(0);
    tick();
    start = 1'b0;
    chk("t3a_cfg_err", cfg_err, 1);
    chk("t3a_busy", busy, 0);
    tick();
    chk("t3a_cfg_err_clear", cfg_err, 0);
    start = 1'b1; pix = CW'(0); num = IW'(3);
    tick();
    start = 1'b0;
    chk("t3b_cfg_err", cfg_err, 1);
    chk("t3b_busy", busy, 0);
    tick();
    chk("t3b_cfg_err_clear", cfg_err, 0);
    chk("t3b_busy_later", busy, 0);

    // 4: single-pixel layer
    load_layer(1, 1);
    wait_done("t4", 30);

    // 5: reset in the middle of a long layer
    load_layer(100, 5);
    k = 0;
    while (fmap_idx != 2 && k < 400) begin tick(); k++; end
    if (k >= 400) fail_now("t5_reach", "never reached fmap_idx=2");
    rst = 1'b1;
    iss_q.delete(); out_q.delete(); lat_q.delete();
    tick();
    chk("t5_count", count, 0);
    chk("t5_fmap_idx", fmap_idx, 0);
    chk("t5_fmap_end", fmap_end, 0);
    chk("t5_issue", issue, 0);
    chk("t5_output_en", output_en, 0);
    chk("t5_fmap_idx_dly", fmap_idx_dly, 0);
    chk("t5_fmap_end_dly", fmap_end_dly, 0);
    chk("t5_busy", busy, 0);
    chk("t5_layer_done", layer_done, 0);
    chk("t5_cfg_err", cfg_err, 0);
    rst = 1'b0;
    tick();
    load_layer(3, 2);
    wait_done("t5_clean", 40);

    // 6: depth-1 instance, start held through the layer
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 3; c++) out_b_q.push_back(f);
    start_b = 1'b1; pix_b = CW'(3); num_b = IW'(2);
    k = 0;
    while (!layer_done_b && k < 40) begin tick(); k++; end
    if (k >= 40) fail_now("t6_done", "timeout waiting for layer_done");
    start_b = 1'b0;
    tick(); tick(); tick();
    chk("t6_outputs", nout_b, 6);
    chk("t6_issues", nissue_b, 6);
    chk("t6_layer_done", ndone_b, 1);
    chk("t6_busy", busy_b, 0);
    chk("t6_out_left", out_b_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
